// File: rtl/wb_stage.sv
// Writeback stage: merges single-cycle ALU results with a small in-order FIFO of
// load results onto one register-file write port, and tracks outstanding long writes.
module wb_stage #(
    parameter int LD_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        issue_valid,
    input  logic        issue_long,
    input  logic [4:0]  issue_rd,
    output logic [31:0] busy_mask,
    output logic        en_write,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        ovf_err
);

    localparam int PTR_W = $clog2(LD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (LD_DEPTH < 2 || (LD_DEPTH & (LD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("LD_DEPTH must be a power of 2 and at least 2");
    end

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [36:0]      mem [LD_DEPTH];

    logic        push;
    logic        pop;
    logic        sel_valid;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic [4:0]  head_rd;
    logic [31:0] busy_next;

    assign ld_ready = (count < CNT_W'(LD_DEPTH));
    assign push     = ld_valid && ld_ready;
    assign head_rd  = mem[head][36:32];

    // ALU results always win the write port; the FIFO only drains in ALU-free cycles.
    always_comb begin
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (count != '0) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_rd    = head_rd;
            sel_data  = mem[head][31:0];
        end
    end

    // A new outstanding write to the same register outranks retirement of the older one.
    always_comb begin
        busy_next = busy_mask;
        if (pop) begin
            busy_next[head_rd] = 1'b0;
        end
        if (issue_valid && issue_long && issue_rd != 5'd0) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {ld_rd, ld_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            busy_mask <= '0;
            en_write  <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            ovf_err   <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            busy_mask <= busy_next;
            // Writes to x0 still consume their source but never reach the register file.
            en_write <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                waddr <= sel_rd;
                wdata <= sel_data;
            end
            if (ld_valid && !ld_ready) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: ALU path, load FIFO ordering/overflow,
// scoreboard races, x0 handling and asynchronous reset.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        issue_valid;
    logic        issue_long;
    logic [4:0]  issue_rd;
    logic [31:0] busy_mask;
    logic        en_write;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ovf_err;

    int checks = 0;
    int errors = 0;

    wb_stage #(.LD_DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .alu_valid(alu_valid),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_rd(ld_rd),
        .ld_data(ld_data),
        .issue_valid(issue_valid),
        .issue_long(issue_long),
        .issue_rd(issue_rd),
        .busy_mask(busy_mask),
        .en_write(en_write),
        .waddr(waddr),
        .wdata(wdata),
        .ovf_err(ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic set_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
        ld_valid = v;
        ld_rd    = rd;
        ld_data  = d;
    endtask

    task automatic set_issue(input logic v, input logic lng, input logic [4:0] rd);
        issue_valid = v;
        issue_long  = lng;
        issue_rd    = rd;
    endtask

    initial begin
        rst = 1'b1;
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        set_issue(1'b0, 1'b0, 5'd0);
        #3;
        check_output("rst_en_write", {31'b0, en_write}, 32'd0);
        check_output("rst_waddr", {27'b0, waddr}, 32'd0);
        check_output("rst_wdata", wdata, 32'd0);
        check_output("rst_busy", busy_mask, 32'd0);
        check_output("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
        check_output("rst_ovf", {31'b0, ovf_err}, 32'd0);
        #9 rst = 1'b0;

        // ALU only
        set_alu(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check_output("alu_en", {31'b0, en_write}, 32'd1);
        check_output("alu_waddr", {27'b0, waddr}, 32'd5);
        check_output("alu_wdata", wdata, 32'hDEADBEEF);
        set_alu(1'b0, 5'd0, 32'h0);
        tick();
        check_output("alu_idle_en", {31'b0, en_write}, 32'd0);
        check_output("alu_idle_waddr_hold", {27'b0, waddr}, 32'd5);
        check_output("alu_idle_wdata_hold", wdata, 32'hDEADBEEF);

        // ALU priority over a queued load
        set_alu(1'b1, 5'd3, 32'h0000000A);
        set_ld(1'b1, 5'd7, 32'h00000011);
        set_issue(1'b1, 1'b1, 5'd7);
        tick();
        check_output("prio_w1_addr", {27'b0, waddr}, 32'd3);
        check_output("prio_w1_data", wdata, 32'h0000000A);
        check_output("prio_busy7_set", busy_mask, 32'h00000080);
        set_ld(1'b0, 5'd0, 32'h0);
        set_issue(1'b0, 1'b0, 5'd0);
        set_alu(1'b1, 5'd3, 32'h0000000B);
        tick();
        check_output("prio_w2_addr", {27'b0, waddr}, 32'd3);
        check_output("prio_w2_data", wdata, 32'h0000000B);
        check_output("prio_busy7_held", busy_mask, 32'h00000080);
        set_alu(1'b0, 5'd0, 32'h0);
        tick();
        check_output("prio_w3_en", {31'b0, en_write}, 32'd1);
        check_output("prio_w3_addr", {27'b0, waddr}, 32'd7);
        check_output("prio_w3_data", wdata, 32'h00000011);
        check_output("prio_busy7_clr", busy_mask, 32'd0);
        tick();
        check_output("prio_drained", {31'b0, en_write}, 32'd0);

        // Full FIFO, overflow, in-order drain across pointer wrap
        set_alu(1'b1, 5'd1, 32'h00000001);
        set_ld(1'b1, 5'd10, 32'h000000AA);
        tick();
        check_output("full_ready_1", {31'b0, ld_ready}, 32'd1);
        set_ld(1'b1, 5'd11, 32'h000000BB);
        tick();
        check_output("full_ready_0", {31'b0, ld_ready}, 32'd0);
        check_output("full_no_ovf", {31'b0, ovf_err}, 32'd0);
        set_ld(1'b1, 5'd12, 32'h000000CC);
        tick();
        check_output("full_ovf_set", {31'b0, ovf_err}, 32'd1);
        check_output("full_still_full", {31'b0, ld_ready}, 32'd0);
        set_ld(1'b0, 5'd0, 32'h0);
        set_alu(1'b0, 5'd0, 32'h0);
        tick();
        check_output("full_pop1_addr", {27'b0, waddr}, 32'd10);
        check_output("full_pop1_data", wdata, 32'h000000AA);
        check_output("full_ready_again", {31'b0, ld_ready}, 32'd1);
        tick();
        check_output("full_pop2_addr", {27'b0, waddr}, 32'd11);
        check_output("full_pop2_data", wdata, 32'h000000BB);
        tick();
        check_output("full_dropped_absent", {31'b0, en_write}, 32'd0);
        check_output("full_ovf_sticky", {31'b0, ovf_err}, 32'd1);

        // Scoreboard race on x9
        set_alu(1'b1, 5'd1, 32'h00000001);
        set_ld(1'b1, 5'd9, 32'h00000099);
        set_issue(1'b1, 1'b1, 5'd9);
        tick();
        check_output("race_busy9", busy_mask, 32'h00000200);
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        tick();
        check_output("race_w_en", {31'b0, en_write}, 32'd1);
        check_output("race_w_addr", {27'b0, waddr}, 32'd9);
        check_output("race_w_data", wdata, 32'h00000099);
        check_output("race_busy9_kept", busy_mask, 32'h00000200);
        set_issue(1'b0, 1'b0, 5'd0);
        set_ld(1'b1, 5'd9, 32'h0000009A);
        tick();
        check_output("race_push_idle", {31'b0, en_write}, 32'd0);
        set_ld(1'b0, 5'd0, 32'h0);
        tick();
        check_output("race_w2_data", wdata, 32'h0000009A);
        check_output("race_busy_clear", busy_mask, 32'd0);

        // x0 handling
        set_alu(1'b1, 5'd2, 32'h00000002);
        set_ld(1'b1, 5'd0, 32'h00000055);
        set_issue(1'b1, 1'b1, 5'd8);
        tick();
        check_output("x0_busy8", busy_mask, 32'h00000100);
        set_issue(1'b0, 1'b0, 5'd0);
        set_ld(1'b1, 5'd8, 32'h00000088);
        tick();
        check_output("x0_full", {31'b0, ld_ready}, 32'd0);
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        set_issue(1'b1, 1'b1, 5'd0);
        tick();
        check_output("x0_pop_no_write", {31'b0, en_write}, 32'd0);
        check_output("x0_count_dec", {31'b0, ld_ready}, 32'd1);
        check_output("x0_busy_unchanged", busy_mask, 32'h00000100);
        set_issue(1'b0, 1'b0, 5'd0);
        tick();
        check_output("x0_next_addr", {27'b0, waddr}, 32'd8);
        check_output("x0_next_data", wdata, 32'h00000088);
        check_output("x0_busy_clear", busy_mask, 32'd0);

        // Reset mid-stream
        set_alu(1'b1, 5'd1, 32'h00000001);
        set_ld(1'b1, 5'd4, 32'h00000044);
        set_issue(1'b1, 1'b1, 5'd4);
        tick();
        set_ld(1'b1, 5'd6, 32'h00000066);
        set_issue(1'b1, 1'b1, 5'd6);
        tick();
        check_output("mid_busy46", busy_mask, 32'h00000050);
        check_output("mid_full", {31'b0, ld_ready}, 32'd0);
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        set_issue(1'b0, 1'b0, 5'd0);
        #2 rst = 1'b1;
        #1;
        check_output("mid_rst_busy", busy_mask, 32'd0);
        check_output("mid_rst_ready", {31'b0, ld_ready}, 32'd1);
        check_output("mid_rst_en", {31'b0, en_write}, 32'd0);
        check_output("mid_rst_ovf", {31'b0, ovf_err}, 32'd0);
        rst = 1'b0;
        tick();
        check_output("post_rst_no_write1", {31'b0, en_write}, 32'd0);
        tick();
        check_output("post_rst_no_write2", {31'b0, en_write}, 32'd0);
        check_output("post_rst_waddr", {27'b0, waddr}, 32'd0);
        check_output("post_rst_busy", busy_mask, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
